// File: rtl/eject_buffer_pkg.sv
// Shared sizing for the local ejection path: router flit width and ejection buffer depth.
// These stand in for the router-wide IN_ROUTER_SIZE / EJECT_DEPTH defines.
package eject_buffer_pkg;

    localparam int IN_ROUTER_SIZE = 16;
    localparam int EJECT_DEPTH    = 4;

    // Pointer advance; DEPTH is a power of two so natural wrap is modulo DEPTH.
    function automatic logic [$clog2(EJECT_DEPTH)-1:0] ptrNext(
        input logic [$clog2(EJECT_DEPTH)-1:0] ptr
    );
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/flit_fifo_ram.sv
// DEPTH x WIDTH flit storage: synchronous write, asynchronous read, storage never reset.
module flit_fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/eject_buffer.sv
// Local ejection buffer: absorbs flits steered to the PE and raises ejectFull so the
// router deflects instead of ejecting when no slot is free.
module eject_buffer
    import eject_buffer_pkg::*;
#(
    parameter  int WIDTH = IN_ROUTER_SIZE,
    parameter  int DEPTH = EJECT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flitIn,
    input  logic             flitInValid,
    output logic             ejectFull,
    output logic [WIDTH-1:0] flitOut,
    output logic             flitOutValid,
    input  logic             flitOutReady,
    output logic [CNT_W-1:0] count,
    output logic             overflowErr
);

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [WIDTH-1:0] rdData;
    logic             push;
    logic             pop;

    // Full flag comes from registered count only, so the router's select logic
    // never sees a path back from flitInValid or flitOutReady.
    assign ejectFull    = (count == CNT_W'(DEPTH));
    assign flitOutValid = (count != '0);
    assign push         = flitInValid & ~ejectFull;
    assign pop          = flitOutValid & flitOutReady;
    assign flitOut      = flitOutValid ? rdData : '0;

    flit_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) uRam (
        .clk    (clk),
        .wrEn   (push & ~reset),
        .wrAddr (wrPtr),
        .wrData (flitIn),
        .rdAddr (rdPtr),
        .rdData (rdData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            overflowErr <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A flit arriving while full means the router ignored ejectFull.
            if (flitInValid && ejectFull) begin
                overflowErr <= 1'b1;
            end
        end
    end

endmodule
